// File: rtl/pipe_stage_buf.sv
// Elastic two-entry pipeline-stage register (main + skid) with valid/ready handshake,
// synchronous flush, hazard freeze and a saturating stall-cycle counter.
//
// state | meaning
// ------+-----------------------------------------------
// EMPTY | no buffered payload, main register stale
// ONE   | main register holds the head payload
// FULL  | main holds the head, skid holds the next one
module pipe_stage_buf #(
    parameter int               WIDTH         = 32,
    parameter logic [WIDTH-1:0] RESET_PAYLOAD = '0,
    parameter bit               FLUSH_CLEARS  = 1'b1,
    parameter int               CNT_WIDTH     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    input  logic                 stall,
    input  logic                 flush,
    output logic [1:0]           occupancy,
    output logic [CNT_WIDTH-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             acc;
    logic             rel;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid_in;

    assign acc      = in_valid & in_ready;
    assign rel      = out_valid & out_ready & ~stall;
    assign out_data = main_q;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid_in   = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    state_nxt    = ONE;
                    load_main_in = 1'b1;
                end
            end
            ONE: begin
                if (acc && !rel) begin
                    state_nxt    = FULL;
                    load_skid_in = 1'b1;
                end else if (acc && rel) begin
                    load_main_in = 1'b1;
                end else if (rel) begin
                    state_nxt = EMPTY;
                end
            end
            FULL: begin
                if (rel) begin
                    state_nxt      = ONE;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
        // Flush overrides everything; an accept in this cycle is silently discarded.
        if (flush) begin
            state_nxt      = EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid_in   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            occupancy <= 2'd0;
            main_q    <= RESET_PAYLOAD;
            skid_q    <= RESET_PAYLOAD;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != FULL);
            case (state_nxt)
                EMPTY:   occupancy <= 2'd0;
                ONE:     occupancy <= 2'd1;
                default: occupancy <= 2'd2;
            endcase

            if (flush && FLUSH_CLEARS) begin
                main_q <= RESET_PAYLOAD;
                skid_q <= RESET_PAYLOAD;
            end else begin
                if (load_main_in)
                    main_q <= in_data;
                else if (load_main_skid)
                    main_q <= skid_q;
                if (load_skid_in)
                    skid_q <= in_data;
            end

            if (out_valid && (!out_ready || stall) && (stall_cnt != CNT_MAX))
                stall_cnt <= stall_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
